// File: rtl/align_pipe_if.sv
// Handshake and datapath bundle for align_pipe.
// The slave modport is the pipeline side; the master modport is the producer/consumer side.
interface align_pipe_if #(
  parameter int LANES     = 4,
  parameter int PP_W      = 3,
  parameter int EXP_W     = 6,
  parameter int SHIFT_MAX = 11
);
  localparam int OUT_W = 1 + PP_W + SHIFT_MAX;

  logic                        i_valid;
  logic                        o_in_ready;
  logic [LANES*(PP_W+1)-1:0]   i_pp;
  logic [LANES*EXP_W-1:0]      i_exp;
  logic                        i_use_ext;
  logic [EXP_W-1:0]            i_ext_max;
  logic                        o_valid;
  logic                        i_out_ready;
  logic [LANES*OUT_W-1:0]      o_align_pp;
  logic [LANES-1:0]            o_sticky;
  logic [LANES-1:0]            o_ovf;
  logic [EXP_W-1:0]            o_max_exp;

  modport slave (
    input  i_valid, i_pp, i_exp, i_use_ext, i_ext_max, i_out_ready,
    output o_in_ready, o_valid, o_align_pp, o_sticky, o_ovf, o_max_exp
  );

  modport master (
    output i_valid, i_pp, i_exp, i_use_ext, i_ext_max, i_out_ready,
    input  o_in_ready, o_valid, o_align_pp, o_sticky, o_ovf, o_max_exp
  );
endinterface

// File: rtl/align_pipe.sv
// Two-stage partial-product aligner: stage 1 picks the alignment exponent,
// stage 2 shifts each lane's mantissa into a fixed-point field and applies its sign.
module align_pipe #(
  parameter int LANES     = 4,
  parameter int PP_W      = 3,
  parameter int EXP_W     = 6,
  parameter int SHIFT_MAX = 11
) (
  input logic         i_clk,
  input logic         i_rst_n,
  align_pipe_if.slave bus
);
  localparam int OUT_W  = 1 + PP_W + SHIFT_MAX;
  localparam int FLD_W  = PP_W + SHIFT_MAX;
  localparam int LANE_W = PP_W + 1;

  logic                      s1Valid_q;
  logic [LANES*LANE_W-1:0]   s1Pp_q;
  logic [LANES*EXP_W-1:0]    s1Exp_q;
  logic                      s1UseExt_q;
  logic [EXP_W-1:0]          s1E_q;
  logic [EXP_W-1:0]          s1E_d;
  logic [EXP_W-1:0]          intMax;

  logic                      s2Valid_q;
  logic [LANES*OUT_W-1:0]    s2Align_q, s2Align_d;
  logic [LANES-1:0]          s2Sticky_q, s2Sticky_d;
  logic [LANES-1:0]          s2Ovf_q, s2Ovf_d;
  logic [EXP_W-1:0]          s2MaxExp_q;

  logic                      s2Load;
  logic                      s1Advance;
  logic                      s1Load;

  logic [PP_W-1:0]           mant;
  logic                      sign;
  logic [EXP_W-1:0]          laneExp;
  logic [EXP_W-1:0]          diff;
  logic [2*FLD_W-1:0]        shifted;
  logic [FLD_W-1:0]          fld;
  logic                      stick;

  assign s2Load         = !s2Valid_q || bus.i_out_ready;
  assign s1Advance      = !s1Valid_q || s2Load;
  assign s1Load         = s1Advance && bus.i_valid;
  assign bus.o_in_ready = s1Advance;

  // Lanes with a zero mantissa contribute nothing, so they must not set the alignment point.
  always_comb begin
    intMax = '0;
    for (int k = 0; k < LANES; k++) begin
      if ((|bus.i_pp[k*LANE_W +: PP_W]) && (bus.i_exp[k*EXP_W +: EXP_W] > intMax)) begin
        intMax = bus.i_exp[k*EXP_W +: EXP_W];
      end
    end
    s1E_d = bus.i_use_ext ? bus.i_ext_max : intMax;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1Valid_q  <= 1'b0;
      s1Pp_q     <= '0;
      s1Exp_q    <= '0;
      s1UseExt_q <= 1'b0;
      s1E_q      <= '0;
    end else begin
      if (s1Advance) begin
        s1Valid_q <= bus.i_valid;
      end
      if (s1Load) begin
        s1Pp_q     <= bus.i_pp;
        s1Exp_q    <= bus.i_exp;
        s1UseExt_q <= bus.i_use_ext;
        s1E_q      <= s1E_d;
      end
    end
  end

  // The mantissa sits above FLD_W guard zeros so everything shifted past bit 0 feeds sticky.
  always_comb begin
    s2Align_d  = '0;
    s2Sticky_d = '0;
    s2Ovf_d    = '0;
    mant       = '0;
    sign       = 1'b0;
    laneExp    = '0;
    diff       = '0;
    shifted    = '0;
    fld        = '0;
    stick      = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      mant    = s1Pp_q[k*LANE_W +: PP_W];
      sign    = s1Pp_q[k*LANE_W + PP_W];
      laneExp = s1Exp_q[k*EXP_W +: EXP_W];
      diff    = s1E_q - laneExp;
      shifted = {mant, {(SHIFT_MAX + FLD_W){1'b0}}} >> diff;
      fld     = '0;
      stick   = 1'b0;
      if (laneExp > s1E_q) begin
        s2Ovf_d[k] = s1UseExt_q;
      end else if (32'(diff) >= FLD_W) begin
        stick = |mant;
      end else begin
        fld   = shifted[2*FLD_W-1 -: FLD_W];
        stick = |shifted[FLD_W-1:0];
      end
      s2Sticky_d[k]               = stick;
      s2Align_d[k*OUT_W +: OUT_W] = sign ? ((~{1'b0, fld}) + OUT_W'(1)) : {1'b0, fld};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2Valid_q  <= 1'b0;
      s2Align_q  <= '0;
      s2Sticky_q <= '0;
      s2Ovf_q    <= '0;
      s2MaxExp_q <= '0;
    end else if (s2Load) begin
      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) begin
        s2Align_q  <= s2Align_d;
        s2Sticky_q <= s2Sticky_d;
        s2Ovf_q    <= s2Ovf_d;
        s2MaxExp_q <= s1E_q;
      end
    end
  end

  assign bus.o_valid    = s2Valid_q;
  assign bus.o_align_pp = s2Align_q;
  assign bus.o_sticky   = s2Sticky_q;
  assign bus.o_ovf      = s2Ovf_q;
  assign bus.o_max_exp  = s2MaxExp_q;
endmodule

// File: tb/tb_align_pipe.sv
// Directed bench for align_pipe: hand-computed lane values, backpressure ordering and async reset.
module tb_align_pipe;
  localparam int LANES = 4;
  localparam int PP_W = 3;
  localparam int EXP_W = 6;
  localparam int SHIFT_MAX = 11;

  logic clock;
  logic rstN;
  int   testsRun;
  int   testsFailed;

  align_pipe_if #(.LANES(LANES), .PP_W(PP_W), .EXP_W(EXP_W), .SHIFT_MAX(SHIFT_MAX)) bus ();

  align_pipe #(.LANES(LANES), .PP_W(PP_W), .EXP_W(EXP_W), .SHIFT_MAX(SHIFT_MAX)) dut (
    .i_clk   (clock),
    .i_rst_n (rstN),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkLanes(input string tag, input logic [59:0] align, input logic [3:0] sticky,
                            input logic [3:0] ovf, input logic [5:0] maxExp);
    checkOutput({tag, "_align"}, 64'(bus.o_align_pp), 64'(align));
    checkOutput({tag, "_sticky"}, 64'(bus.o_sticky), 64'(sticky));
    checkOutput({tag, "_ovf"}, 64'(bus.o_ovf), 64'(ovf));
    checkOutput({tag, "_maxexp"}, 64'(bus.o_max_exp), 64'(maxExp));
  endtask

  task automatic applyStimulus(input logic [15:0] pp, input logic [23:0] exps,
                               input logic useExt, input logic [5:0] extMax);
    @(negedge clock);
    bus.i_pp      = pp;
    bus.i_exp     = exps;
    bus.i_use_ext = useExt;
    bus.i_ext_max = extMax;
    bus.i_valid   = 1'b1;
  endtask

  // Sends one beat into an empty pipeline and leaves the bench on the cycle its result is valid.
  task automatic runBeat(input string tag, input logic [15:0] pp, input logic [23:0] exps,
                         input logic useExt, input logic [5:0] extMax);
    applyStimulus(pp, exps, useExt, extMax);
    @(negedge clock);
    checkOutput({tag, "_lat1_valid"}, 64'(bus.o_valid), 64'(0));
    bus.i_valid = 1'b0;
    @(negedge clock);
    checkOutput({tag, "_lat2_valid"}, 64'(bus.o_valid), 64'(1));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    testsRun      = 0;
    testsFailed   = 0;
    rstN          = 1'b0;
    bus.i_valid   = 1'b0;
    bus.i_pp      = '0;
    bus.i_exp     = '0;
    bus.i_use_ext = 1'b0;
    bus.i_ext_max = '0;
    bus.i_out_ready = 1'b1;

    repeat (2) @(negedge clock);
    checkOutput("rst_valid", 64'(bus.o_valid), 64'(0));
    checkOutput("rst_in_ready", 64'(bus.o_in_ready), 64'(1));
    checkLanes("rst", 60'h0, 4'h0, 4'h0, 6'd0);
    rstN = 1'b1;

    runBeat("intmax", 16'h5555, {6'd0, 6'd7, 6'd10, 6'd10}, 1'b0, 6'd0);
    checkLanes("intmax", {15'h000A, 15'h0500, 15'h2800, 15'h2800}, 4'h0, 4'h0, 6'd10);

    runBeat("neg", 16'hF78C, {6'd5, 6'd3, 6'd5, 6'd5}, 1'b0, 6'd40);
    checkLanes("neg", {15'h4800, 15'h0E00, 15'h0000, 15'h6000}, 4'h0, 4'h0, 6'd5);

    runBeat("deep13", 16'h0D55, {6'd0, 6'd12, 6'd13, 6'd0}, 1'b1, 6'd13);
    checkLanes("deep13", {15'h0000, 15'h6C00, 15'h2800, 15'h0001}, 4'b0001, 4'h0, 6'd13);

    runBeat("deep20", 16'h0D55, {6'd0, 6'd12, 6'd13, 6'd0}, 1'b1, 6'd20);
    checkLanes("deep20", {15'h0000, 15'h7FD8, 15'h0050, 15'h0000}, 4'b0001, 4'h0, 6'd20);

    runBeat("ovf", 16'h4F65, {6'd0, 6'd4, 6'd5, 6'd7}, 1'b1, 6'd5);
    checkLanes("ovf", {15'h0100, 15'h6400, 15'h3000, 15'h0000}, 4'h0, 4'b0001, 6'd5);

    // Three beats against a stalled consumer; ext_max tags each beat.
    applyStimulus(16'h4444, {4{6'd10}}, 1'b1, 6'd10);
    bus.i_out_ready = 1'b0;
    @(negedge clock);
    checkOutput("bp_ready_s1", 64'(bus.o_in_ready), 64'(1));
    bus.i_ext_max = 6'd11;
    @(negedge clock);
    checkOutput("bp_full_ready", 64'(bus.o_in_ready), 64'(0));
    checkOutput("bp_a_valid", 64'(bus.o_valid), 64'(1));
    checkLanes("bp_a", {4{15'h2000}}, 4'h0, 4'h0, 6'd10);
    bus.i_ext_max = 6'd12;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      checkOutput("bp_hold_ready", 64'(bus.o_in_ready), 64'(0));
      checkOutput("bp_hold_valid", 64'(bus.o_valid), 64'(1));
      checkLanes("bp_hold", {4{15'h2000}}, 4'h0, 4'h0, 6'd10);
    end
    bus.i_out_ready = 1'b1;
    @(negedge clock);
    bus.i_valid   = 1'b0;
    bus.i_use_ext = 1'b0;
    bus.i_ext_max = 6'd63;
    checkOutput("bp_b_valid", 64'(bus.o_valid), 64'(1));
    checkLanes("bp_b", {4{15'h1000}}, 4'h0, 4'h0, 6'd11);
    @(negedge clock);
    checkOutput("bp_c_valid", 64'(bus.o_valid), 64'(1));
    checkLanes("bp_c", {4{15'h0800}}, 4'h0, 4'h0, 6'd12);
    @(negedge clock);
    checkOutput("bp_drained", 64'(bus.o_valid), 64'(0));

    // Asynchronous reset while a result is being held.
    bus.i_out_ready = 1'b0;
    runBeat("prerst", 16'hF78C, {6'd5, 6'd3, 6'd5, 6'd5}, 1'b0, 6'd0);
    #3 rstN = 1'b0;
    #1;
    checkOutput("arst_valid", 64'(bus.o_valid), 64'(0));
    checkOutput("arst_in_ready", 64'(bus.o_in_ready), 64'(1));
    checkLanes("arst", 60'h0, 4'h0, 4'h0, 6'd0);
    @(negedge clock);
    rstN = 1'b1;
    bus.i_out_ready = 1'b1;
    runBeat("postrst", 16'h5555, {6'd0, 6'd7, 6'd10, 6'd10}, 1'b0, 6'd0);
    checkLanes("postrst", {15'h000A, 15'h0500, 15'h2800, 15'h2800}, 4'h0, 4'h0, 6'd10);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
